// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared definitions for the PS/2 LED command sequencer.
//               Holds the keyboard protocol bytes and the sequencer states.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    // Keyboard protocol bytes
    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;
    localparam logic [7:0] PS2_RSP_RESEND   = 8'hFE;

    // State encodings, fixed so external tools can decode the register
    localparam logic [2:0] ST_IDLE         = 3'd0;
    localparam logic [2:0] ST_TX_CMD       = 3'd1;
    localparam logic [2:0] ST_WAIT_ACK_CMD = 3'd2;
    localparam logic [2:0] ST_TX_ARG       = 3'd3;
    localparam logic [2:0] ST_WAIT_ACK_ARG = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE         = ST_IDLE,
        S_TX_CMD       = ST_TX_CMD,
        S_WAIT_ACK_CMD = ST_WAIT_ACK_CMD,
        S_TX_ARG       = ST_TX_ARG,
        S_WAIT_ACK_ARG = ST_WAIT_ACK_ARG
    } ps2_state_t;

endpackage
`default_nettype wire

// File: rtl/ps2_resp_timer.sv
`default_nettype none
// ============================================================================
// Module      : ps2_resp_timer
// Description : Response-wait counter. Cleared by 'clear', counts while
//               'enable' is high, saturates at TIMEOUT_CYCLES-1 and flags it.
// Ports       : clk     in  1  system clock
//               resetn  in  1  synchronous active-low reset
//               clear   in  1  force count to zero (has priority)
//               enable  in  1  count one step per cycle
//               expired out 1  count has reached TIMEOUT_CYCLES-1
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_resp_timer #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // A single-cycle timeout still needs a 1-bit register
    localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] TERMINAL = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;

    // Saturating so a late consumer never sees the flag drop by wrap-around
    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != TERMINAL)) begin
            count <= count + W'(1);
        end
    end

    assign expired = (count == TERMINAL);

endmodule
`default_nettype wire

// File: rtl/ps2_led_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ps2_led_cmd_sequencer
// Description : Host-side Set-LEDs sequencer in front of a PS/2 controller.
//               Sends 0xED, waits ACK, sends the mask byte, waits ACK, with
//               resend/timeout retries. Non-response RX bytes are forwarded.
// Ports       : CLOCK_50                      in  1  system clock
//               resetn                        in  1  synchronous active-low reset
//               led_req / led_mask            in  1/3 start request and LED mask
//               led_busy / led_done / led_error out 1 status and result pulses
//               command_to_send / send_command out 8/1 TX byte and strobe
//               command_was_sent              in  1  controller: byte sent
//               error_communication_timed_out in  1  controller: TX failed
//               received_data / received_data_en in 8/1 controller RX byte
//               key_data / key_data_en        out 8/1 forwarded RX byte
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_led_cmd_sequencer
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int MAX_RETRIES    = 3
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       led_req,
    input  logic [2:0] led_mask,
    output logic       led_busy,
    output logic       led_done,
    output logic       led_error,
    output logic [7:0] command_to_send,
    output logic       send_command,
    input  logic       command_was_sent,
    input  logic       error_communication_timed_out,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    output logic [7:0] key_data,
    output logic       key_data_en
);

    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRIES);

    ps2_state_t    state;
    logic [7:0]    mask_byte;
    logic [RW-1:0] retries;
    logic          in_tx;
    logic          in_wait;
    logic          rx_ack;
    logic          rx_resend;
    logic          rx_consumed;
    logic          timer_expired;

    assign in_tx       = (state == S_TX_CMD) || (state == S_TX_ARG);
    assign in_wait     = (state == S_WAIT_ACK_CMD) || (state == S_WAIT_ACK_ARG);
    assign rx_ack      = received_data_en && (received_data == PS2_RSP_ACK);
    assign rx_resend   = received_data_en && (received_data == PS2_RSP_RESEND);
    // Responses are only swallowed while one is actually expected
    assign rx_consumed = in_wait && (rx_ack || rx_resend);

    // Held at zero outside the wait states so every wait starts from 0
    ps2_resp_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_resp_timer (
        .clk     (CLOCK_50),
        .resetn  (resetn),
        .clear   (!in_wait),
        .enable  (in_wait),
        .expired (timer_expired)
    );

    assign led_busy     = (state != S_IDLE);
    assign send_command = in_tx;

    always_comb begin
        command_to_send = 8'h00;
        case (state)
            S_TX_CMD: command_to_send = PS2_CMD_SET_LEDS;
            S_TX_ARG: command_to_send = mask_byte;
            default:  command_to_send = 8'h00;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state       <= S_IDLE;
            mask_byte   <= 8'h00;
            retries     <= '0;
            led_done    <= 1'b0;
            led_error   <= 1'b0;
            key_data    <= 8'h00;
            key_data_en <= 1'b0;
        end else begin
            led_done    <= 1'b0;
            led_error   <= 1'b0;
            key_data_en <= received_data_en && !rx_consumed;
            if (received_data_en && !rx_consumed) begin
                key_data <= received_data;
            end

            case (state)
                S_IDLE: begin
                    if (led_req) begin
                        mask_byte <= {5'b0, led_mask};
                        retries   <= '0;
                        state     <= S_TX_CMD;
                    end
                end

                S_TX_CMD, S_TX_ARG: begin
                    // A reported TX failure wins over a coincident 'sent'
                    if (error_communication_timed_out) begin
                        led_error <= 1'b1;
                        state     <= S_IDLE;
                    end else if (command_was_sent) begin
                        state <= (state == S_TX_CMD) ? S_WAIT_ACK_CMD : S_WAIT_ACK_ARG;
                    end
                end

                S_WAIT_ACK_CMD, S_WAIT_ACK_ARG: begin
                    // Checking the byte first lets it win over a same-cycle expiry
                    if (rx_ack) begin
                        retries <= '0;
                        if (state == S_WAIT_ACK_CMD) begin
                            state <= S_TX_ARG;
                        end else begin
                            led_done <= 1'b1;
                            state    <= S_IDLE;
                        end
                    end else if (rx_resend || timer_expired) begin
                        if (retries < RETRY_LIMIT) begin
                            retries <= retries + RW'(1);
                            state   <= (state == S_WAIT_ACK_CMD) ? S_TX_CMD : S_TX_ARG;
                        end else begin
                            led_error <= 1'b1;
                            state     <= S_IDLE;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_led_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_led_cmd_sequencer
// Description : Self-checking bench for ps2_led_cmd_sequencer. A transaction
//               model predicts TX bytes and the exchange result from the
//               keyboard responses; a negedge process compares every cycle.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_led_cmd_sequencer;
    import ps2_pkg::*;

    localparam int TO = 64;
    localparam int MR = 2;

    localparam int K_ACK     = 0;
    localparam int K_RESEND  = 1;
    localparam int K_TIMEOUT = 2;
    localparam int K_TXFAIL  = 3;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       led_req = 1'b0;
    logic [2:0] led_mask = 3'b000;
    logic       led_busy, led_done, led_error;
    logic [7:0] command_to_send;
    logic       send_command;
    logic       command_was_sent = 1'b0;
    logic       error_communication_timed_out = 1'b0;
    logic [7:0] received_data = 8'h00;
    logic       received_data_en = 1'b0;
    logic [7:0] key_data;
    logic       key_data_en;

    always #5 clk = ~clk;

    ps2_led_cmd_sequencer #(
        .TIMEOUT_CYCLES (TO),
        .MAX_RETRIES    (MR)
    ) dut (
        .CLOCK_50                      (clk),
        .resetn                        (resetn),
        .led_req                       (led_req),
        .led_mask                      (led_mask),
        .led_busy                      (led_busy),
        .led_done                      (led_done),
        .led_error                     (led_error),
        .command_to_send               (command_to_send),
        .send_command                  (send_command),
        .command_was_sent              (command_was_sent),
        .error_communication_timed_out (error_communication_timed_out),
        .received_data                 (received_data),
        .received_data_en              (received_data_en),
        .key_data                      (key_data),
        .key_data_en                   (key_data_en)
    );

    int         n_checks = 0;
    int         n_pass   = 0;
    int         tk       = 0;
    int         ncyc     = 0;
    int         done_cnt = 0;
    int         err_cnt  = 0;
    int         ctl_cnt  = 0;
    bit         fail_next = 1'b0;
    bit         sent_now  = 1'b0;
    bit         txerr_now = 1'b0;
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, req, $time);
    endtask

    function automatic logic [7:0] rand_key();
        logic [7:0] b;
        do b = 8'($urandom_range(0, 255));
        while (b == PS2_RSP_ACK || b == PS2_RSP_RESEND);
        return b;
    endfunction

    // Transaction-level model: which bytes go out and how the exchange ends,
    // given the keyboard's reaction to each transmission in order.
    task automatic model_exchange(input logic [2:0] mask, input int plan[8],
                                  output logic [7:0] txb[8], output int ntx, output bit ok);
        logic [7:0] cur = PS2_CMD_SET_LEDS;
        int tries = 0;
        ntx = 0;
        ok  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            txb[ntx] = cur;
            ntx++;
            if (plan[i] == K_ACK) begin
                if (cur == PS2_CMD_SET_LEDS) begin
                    cur   = {5'b0, mask};
                    tries = 0;
                end else begin
                    ok = 1'b1;
                    return;
                end
            end else if (plan[i] == K_TXFAIL) begin
                return;
            end else if (tries < MR) begin
                tries++;
            end else begin
                return;
            end
        end
    endtask

    // One clock step; inputs change 1 time unit after the edge. The embedded
    // controller model acknowledges each TX on its 10th strobed cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        tk++;
        received_data_en = 1'b0;
        command_was_sent = 1'b0;
        error_communication_timed_out = 1'b0;
        led_req   = 1'b0;
        sent_now  = 1'b0;
        txerr_now = 1'b0;
        if (send_command) begin
            ctl_cnt++;
            if (ctl_cnt == 10) begin
                ctl_cnt = 0;
                if (fail_next) begin
                    error_communication_timed_out = 1'b1;
                    fail_next = 1'b0;
                    txerr_now = 1'b1;
                end else begin
                    command_was_sent = 1'b1;
                    sent_now = 1'b1;
                end
            end
        end else begin
            ctl_cnt = 0;
        end
    endtask

    // Compare process: reset values, forwarding, TX bytes, pulse rules
    initial begin
        bit         exp_fwd = 1'b0;
        logic [7:0] exp_key = 8'h00;
        bit         prev_rst = 1'b1;
        bit         prev_send = 1'b0;
        logic [7:0] prev_cmd = 8'h00;
        bit         wait_active = 1'b0;
        int         wait_s = 0;
        bit         consumed;
        forever begin
            @(negedge clk);
            ncyc++;
            if (prev_rst) begin
                chk("rst_busy", 32'(led_busy), 0);
                chk("rst_done", 32'(led_done), 0);
                chk("rst_error", 32'(led_error), 0);
                chk("rst_send", 32'(send_command), 0);
                chk("rst_cmd", 32'(command_to_send), 0);
                chk("rst_key", 32'(key_data), 0);
                chk("rst_key_en", 32'(key_data_en), 0);
            end else begin
                chk("key_data_en", 32'(key_data_en), 32'(exp_fwd));
                if (exp_fwd) chk("key_data", 32'(key_data), 32'(exp_key));
                if (led_done || led_error) begin
                    chk("done_error_exclusive", 32'(led_done & led_error), 0);
                    chk("busy_at_pulse", 32'(led_busy), 0);
                end
                if (send_command && !prev_send) begin
                    chk("tx_pending", 32'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) chk("tx_byte", 32'(command_to_send), 32'(exp_q.pop_front()));
                end else if (send_command) begin
                    chk("tx_stable", 32'(command_to_send), 32'(prev_cmd));
                end
                if (led_done)  done_cnt++;
                if (led_error) err_cnt++;
            end
            prev_send = send_command;
            prev_cmd  = command_to_send;

            // A response is awaited for TO cycles after each accepted byte
            if (wait_active && (ncyc - wait_s > TO)) wait_active = 1'b0;
            if (!resetn) begin
                exp_fwd     = 1'b0;
                wait_active = 1'b0;
            end else begin
                consumed = wait_active && received_data_en &&
                           (received_data == PS2_RSP_ACK || received_data == PS2_RSP_RESEND);
                exp_fwd = received_data_en && !consumed;
                if (exp_fwd) exp_key = received_data;
                if (consumed) wait_active = 1'b0;
                if (command_was_sent) begin
                    wait_active = 1'b1;
                    wait_s      = ncyc;
                end
            end
            prev_rst = !resetn;
        end
    end

    task automatic run_exchange(input logic [2:0] mask, input int plan[8], input bit busy_req,
                                input bit force_1c, input bit idle_rx, input int fixed_d);
        logic [7:0] txb[8];
        int ntx, d0, e0, t0, d, nat;
        bit ok, got;
        model_exchange(mask, plan, txb, ntx, ok);
        for (int i = 0; i < ntx; i++) exp_q.push_back(txb[i]);
        d0 = done_cnt;
        e0 = err_cnt;
        led_req  = 1'b1;
        led_mask = mask;
        if (idle_rx) begin
            received_data    = 8'($urandom_range(0, 255));
            received_data_en = 1'b1;
        end
        for (int a = 0; a < ntx; a++) begin
            if (plan[a] == K_TXFAIL) fail_next = 1'b1;
            got = 1'b0;
            for (int w = 0; w < 200 && !got; w++) begin
                tick();
                got = (plan[a] == K_TXFAIL) ? txerr_now : sent_now;
            end
            chk("handshake_seen", 32'(got), 1);
            if (!got) break;
            t0 = tk;
            if (plan[a] == K_TIMEOUT) begin
                if (a < ntx - 1) begin
                    got = 1'b0;
                    for (int w = 0; w < 200 && !got; w++) begin
                        tick();
                        got = send_command;
                    end
                    // TO wait cycles follow the sampling edge; TX shows one tick later
                    chk("timeout_resend_gap", 32'(tk - t0), TO + 1);
                end
            end else if (plan[a] != K_TXFAIL) begin
                d   = (fixed_d > 0) ? fixed_d : int'($urandom_range(1, TO));
                nat = 0;
                if (force_1c && a == 0) begin
                    if (d < 2) d = 2;
                    nat = 1;
                end else if (!force_1c && d >= 2 && $urandom_range(0, 1) == 1) begin
                    nat = int'($urandom_range(1, d - 1));
                end
                for (int k = 1; k <= d; k++) begin
                    tick();
                    if (busy_req && k == 1) begin
                        led_req  = 1'b1;
                        led_mask = 3'b111;
                    end
                    if (k == nat) begin
                        received_data    = (force_1c && a == 0) ? 8'h1C : rand_key();
                        received_data_en = 1'b1;
                    end
                    if (k == d) begin
                        received_data    = (plan[a] == K_ACK) ? PS2_RSP_ACK : PS2_RSP_RESEND;
                        received_data_en = 1'b1;
                    end
                end
            end
        end
        got = 1'b0;
        for (int w = 0; w < 300 && !got; w++) begin
            tick();
            got = !led_busy;
        end
        chk("returns_idle", 32'(got), 1);
        tick();
        tick();
        chk("done_pulses", 32'(done_cnt - d0), 32'(ok));
        chk("error_pulses", 32'(err_cnt - e0), 32'(!ok));
        chk("tx_all_sent", 32'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int         p[8];
        logic [7:0] txb[8];
        int         ntx, d0, e0;
        bit         ok, got;

        repeat (4) tick();
        resetn = 1'b1;
        tick();

        // Model pinned against hand-derived outcomes
        p = '{K_ACK, K_ACK, 0, 0, 0, 0, 0, 0};
        model_exchange(3'b101, p, txb, ntx, ok);
        chk("model_aa_ntx", 32'(ntx), 2);
        chk("model_aa_arg", 32'(txb[1]), 32'h05);
        chk("model_aa_ok", 32'(ok), 1);
        p = '{K_RESEND, K_RESEND, K_RESEND, 0, 0, 0, 0, 0};
        model_exchange(3'b101, p, txb, ntx, ok);
        chk("model_rrr_ntx", 32'(ntx), 3);
        chk("model_rrr_ok", 32'(ok), 0);
        p = '{K_ACK, K_TIMEOUT, K_TIMEOUT, K_TIMEOUT, 0, 0, 0, 0};
        model_exchange(3'b101, p, txb, ntx, ok);
        chk("model_attt_ntx", 32'(ntx), 4);
        chk("model_attt_last", 32'(txb[3]), 32'h05);
        p = '{K_RESEND, K_ACK, K_RESEND, K_RESEND, K_ACK, 0, 0, 0};
        model_exchange(3'b011, p, txb, ntx, ok);
        chk("model_retry_clear_ntx", 32'(ntx), 5);
        chk("model_retry_clear_ok", 32'(ok), 1);

        // Basic exchange, resend exhaustion, timeout exhaustion
        run_exchange(3'b101, '{K_ACK, K_ACK, 0, 0, 0, 0, 0, 0}, 1'b0, 1'b0, 1'b0, 0);
        run_exchange(3'b101, '{K_RESEND, K_RESEND, K_RESEND, 0, 0, 0, 0, 0}, 1'b0, 1'b0, 1'b0, 0);
        run_exchange(3'b101, '{K_ACK, K_TIMEOUT, K_TIMEOUT, K_TIMEOUT, 0, 0, 0, 0}, 1'b0, 1'b0, 1'b0, 0);

        // Scan code inside the ACK wait is forwarded, the ACK itself is not
        run_exchange(3'b110, '{K_ACK, K_ACK, 0, 0, 0, 0, 0, 0}, 1'b0, 1'b1, 1'b0, 0);
        chk("fwd_scan_kept", 32'(key_data), 32'h1C);

        // Request while busy is ignored
        run_exchange(3'b001, '{K_ACK, K_ACK, 0, 0, 0, 0, 0, 0}, 1'b1, 1'b0, 1'b0, 0);

        // Response on the expiry cycle wins; TX failure ends with error
        run_exchange(3'b010, '{K_ACK, K_ACK, 0, 0, 0, 0, 0, 0}, 1'b0, 1'b0, 1'b1, TO);
        run_exchange(3'b100, '{K_RESEND, K_RESEND, K_ACK, K_RESEND, K_ACK, 0, 0, 0}, 1'b0, 1'b0, 1'b0, TO);
        run_exchange(3'b011, '{K_ACK, K_TXFAIL, 0, 0, 0, 0, 0, 0}, 1'b0, 1'b0, 1'b1, 0);

        // Reset while the mask byte is being transmitted
        exp_q.push_back(PS2_CMD_SET_LEDS);
        exp_q.push_back(8'h02);
        d0 = done_cnt;
        e0 = err_cnt;
        led_req  = 1'b1;
        led_mask = 3'b010;
        got = 1'b0;
        for (int w = 0; w < 200 && !got; w++) begin
            tick();
            got = sent_now;
        end
        chk("rst_case_cmd_sent", 32'(got), 1);
        repeat (3) tick();
        received_data    = PS2_RSP_ACK;
        received_data_en = 1'b1;
        got = 1'b0;
        for (int w = 0; w < 50 && !got; w++) begin
            tick();
            got = send_command;
        end
        chk("rst_case_in_tx_arg", 32'(got), 1);
        tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk("rst_case_send", 32'(send_command), 0);
        chk("rst_case_busy", 32'(led_busy), 0);
        repeat (3) tick();
        chk("rst_case_no_done", 32'(done_cnt - d0), 0);
        chk("rst_case_no_error", 32'(err_cnt - e0), 0);
        chk("rst_case_tx_seen", 32'(exp_q.size()), 0);
        exp_q.delete();
        run_exchange(3'b101, '{K_ACK, K_ACK, 0, 0, 0, 0, 0, 0}, 1'b0, 1'b0, 1'b0, 0);

        // Randomized exchanges with idle traffic between them
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 8; i++) begin
                int r;
                r = int'($urandom_range(0, 9));
                p[i] = (r <= 5) ? K_ACK : (r <= 7) ? K_RESEND : (r == 8) ? K_TIMEOUT : K_TXFAIL;
            end
            run_exchange(3'($urandom_range(0, 7)), p, 1'($urandom_range(0, 1)), 1'b0,
                         1'($urandom_range(0, 1)), 0);
            for (int i = 0; i < int'($urandom_range(0, 5)); i++) begin
                received_data    = 8'($urandom_range(0, 255));
                received_data_en = 1'b1;
                tick();
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
